// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM single-port memory arbiter: state codes,
// requester ownership encoding and the datapath width.
package mem_port_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  // Owner value doubles as the address mux select (1 = MEM-stage address).
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  function automatic logic parity_w(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_latency_counter.sv
// Memory latency down-counter: loaded with MEM_LAT-1 at launch, counts down
// while enabled, and flags done when it reaches zero.
module mem_port_arbiter_latency_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and MEM pipeline stages:
// arbitrates, launches one access at a time and returns data to the winner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              addr_sel,
  output logic              m_en,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  state_t            state_d,     state_q;
  owner_t            owner_d,     owner_q;
  logic              we_d,        we_q;
  logic [SW-1:0]     starve_d,    starve_q;
  logic              if_gnt_d,    if_gnt_q;
  logic              if_valid_d,  if_valid_q;
  logic [DATA_W-1:0] if_rdata_d,  if_rdata_q;
  logic              mem_gnt_d,   mem_gnt_q;
  logic              mem_valid_d, mem_valid_q;
  logic [DATA_W-1:0] mem_rdata_d, mem_rdata_q;
  logic              addr_sel_d,  addr_sel_q;
  logic              m_en_d,      m_en_q;
  logic              m_we_d,      m_we_q;
  logic [DATA_W-1:0] m_wdata_d,   m_wdata_q;

  logic lat_load;
  logic lat_dec;
  logic lat_done;
  logic if_wins;
  logic unused_if_addr_par;

  // The fetch address is routed to the external mux, never through this block.
  assign unused_if_addr_par = parity_w(if_addr);

  // MEM has priority unless IF has lost STARVE_MAX arbitrations in a row.
  assign if_wins = if_req & (~mem_req | (starve_q == STARVE_LIM));

  mem_port_arbiter_latency_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (lat_load),
    .dec   (lat_dec),
    .done  (lat_done)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    mem_gnt_d   = 1'b0;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    m_en_d      = 1'b0;
    m_we_d      = 1'b0;
    addr_sel_d  = addr_sel_q;
    m_wdata_d   = m_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    lat_load    = 1'b0;
    lat_dec     = 1'b0;
    // Outputs are decoded from the transition so they appear registered in the target state.
    case (state_q)
      ST_IDLE: begin
        addr_sel_d = 1'b0;
        if (if_req || mem_req) begin
          state_d    = ST_ACCESS;
          owner_d    = if_wins ? OWN_IF : OWN_MEM;
          we_d       = ~if_wins & mem_we;
          m_en_d     = 1'b1;
          if_gnt_d   = if_wins;
          mem_gnt_d  = ~if_wins;
          m_we_d     = ~if_wins & mem_we;
          addr_sel_d = ~if_wins;
          m_wdata_d  = if_wins ? '0 : mem_wdata;
          if (if_wins) begin
            starve_d = '0;
          end else if (if_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + STARVE_ONE;
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        lat_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        lat_dec = 1'b1;
        if (lat_done) begin
          state_d = ST_RESP;
          if (owner_q == OWN_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = m_rdata;
          end else begin
            mem_valid_d = 1'b1;
            mem_rdata_d = we_q ? '0 : m_rdata;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        addr_sel_d = 1'b0;
      end
      default: begin
        state_d    = ST_IDLE;
        addr_sel_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_gnt_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rdata_q <= '0;
      addr_sel_q  <= 1'b0;
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      mem_gnt_q   <= mem_gnt_d;
      mem_valid_q <= mem_valid_d;
      mem_rdata_q <= mem_rdata_d;
      addr_sel_q  <= addr_sel_d;
      m_en_q      <= m_en_d;
      m_we_q      <= m_we_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign mem_gnt   = mem_gnt_q;
  assign mem_valid = mem_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign addr_sel  = addr_sel_q;
  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_wdata   = m_wdata_q;
  assign stall_if  = if_req & ~if_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;
  localparam int NRND = 1500;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] m_rdata;

  logic        if_gnt, if_valid, mem_gnt, mem_valid, addr_sel, m_en, m_we, stall_if;
  logic [31:0] if_rdata, mem_rdata, m_wdata;

  logic        d1_if_gnt, d1_if_valid, d1_mem_gnt, d1_mem_valid, d1_addr_sel;
  logic        d1_m_en, d1_m_we, d1_stall_if;
  logic [31:0] d1_if_rdata, d1_mem_rdata, d1_m_wdata;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .addr_sel(addr_sel), .m_en(m_en),
    .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata), .stall_if(stall_if)
  );

  // Second build with single-cycle memory latency, sharing the same stimulus.
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(d1_if_gnt), .if_valid(d1_if_valid), .if_rdata(d1_if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_gnt(d1_mem_gnt),
    .mem_valid(d1_mem_valid), .mem_rdata(d1_mem_rdata), .addr_sel(d1_addr_sel), .m_en(d1_m_en),
    .m_we(d1_m_we), .m_wdata(d1_m_wdata), .m_rdata(m_rdata), .stall_if(d1_stall_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        if_req;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  flags;   // if_gnt if_valid mem_gnt mem_valid addr_sel m_en m_we stall_if
    logic [31:0] if_rd;
    logic [31:0] mem_rd;
    logic [31:0] m_wd;
  } vec_t;

  vec_t vecs[$];
  bit   gq[$];
  int   tq[$];

  // Random-phase model state: one access record plus held output values.
  int          next_free, ca, starve;
  bit          act, own, a_we, if_win;
  logic [31:0] a_wd, a_samp;
  logic [31:0] e_ifrd, e_memrd, e_mwd;
  logic        e_ig, e_iv, e_mg, e_mv, e_as, e_en, e_we;
  bit          if_hold, mem_hold;

  task automatic check(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act_v, exp_v);
    end
  endtask

  function automatic logic [127:0] obs0();
    return {24'h0, if_gnt, if_valid, mem_gnt, mem_valid, addr_sel, m_en, m_we, stall_if,
            if_rdata, mem_rdata, m_wdata};
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = 32'h0; mem_wdata = 32'h0; m_rdata = 32'h0;
    next_cycle();
    next_cycle();
    Reset = 1'b0;
  endtask

  task automatic add(input logic ir, input logic mr, input logic mw, input logic [31:0] wd,
                     input logic [31:0] rd, input logic [7:0] fl, input logic [31:0] ird,
                     input logic [31:0] mrd, input logic [31:0] mwd);
    vec_t v;
    v.if_req = ir; v.mem_req = mr; v.mem_we = mw; v.wdata = wd; v.rdata = rd;
    v.flags = fl; v.if_rd = ird; v.mem_rd = mrd; v.m_wd = mwd;
    vecs.push_back(v);
  endtask

  initial begin
    // Lone IF read (cycles 0..5)
    add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,         8'b0000_0001, 32'h0,         32'h0, 32'h0);
    add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,         8'b1000_0101, 32'h0,         32'h0, 32'h0);
    add(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,         8'b0000_0001, 32'h0,         32'h0, 32'h0);
    add(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 8'b0000_0001, 32'h0,         32'h0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0, 32'h0,         8'b0100_0000, 32'h1234_5678, 32'h0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0, 32'h0,         8'b0000_0000, 32'h1234_5678, 32'h0, 32'h0);
    // Lone MEM write: memory data on the bus must not reach mem_rdata
    add(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,         8'b0000_0000, 32'h1234_5678, 32'h0, 32'h0);
    add(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,         8'b0010_1110, 32'h1234_5678, 32'h0, 32'hDEAD_BEEF);
    add(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 8'b0000_1000, 32'h1234_5678, 32'h0, 32'hDEAD_BEEF);
    add(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hAAAA_5555, 8'b0000_1000, 32'h1234_5678, 32'h0, 32'hDEAD_BEEF);
    add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         8'b0001_1000, 32'h1234_5678, 32'h0, 32'hDEAD_BEEF);
    add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         8'b0000_0000, 32'h1234_5678, 32'h0, 32'hDEAD_BEEF);
    // Simultaneous requests: MEM read wins, IF granted in cycle 6
    add(1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'h0,         8'b0000_0001, 32'h1234_5678, 32'h0,         32'hDEAD_BEEF);
    add(1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'h0,         8'b0010_1101, 32'h1234_5678, 32'h0,         32'h1111_1111);
    add(1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'h0,         8'b0000_1001, 32'h1234_5678, 32'h0,         32'h1111_1111);
    add(1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'hCAFE_F00D, 8'b0000_1001, 32'h1234_5678, 32'h0,         32'h1111_1111);
    add(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         8'b0001_1001, 32'h1234_5678, 32'hCAFE_F00D, 32'h1111_1111);
    add(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         8'b0000_0001, 32'h1234_5678, 32'hCAFE_F00D, 32'h1111_1111);
    add(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         8'b1000_0101, 32'h1234_5678, 32'hCAFE_F00D, 32'h0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         8'b0000_0001, 32'h1234_5678, 32'hCAFE_F00D, 32'h0);
    add(1'b1, 1'b0, 1'b0, 32'h0,         32'h0BAD_C0DE, 8'b0000_0001, 32'h1234_5678, 32'hCAFE_F00D, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         8'b0100_0000, 32'h0BAD_C0DE, 32'hCAFE_F00D, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         8'b0000_0000, 32'h0BAD_C0DE, 32'hCAFE_F00D, 32'h0);

    // Reset state
    do_reset();
    #1;
    check("reset_state", obs0(), 128'h0);

    // Directed table, one entry per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) next_cycle();
      if_req = vecs[i].if_req; mem_req = vecs[i].mem_req; mem_we = vecs[i].mem_we;
      mem_wdata = vecs[i].wdata; m_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d", i), obs0(),
            {24'h0, vecs[i].flags, vecs[i].if_rd, vecs[i].mem_rd, vecs[i].m_wd});
    end

    // Reset in WAIT of a MEM read: access abandoned, next IF request served normally
    do_reset();
    mem_req = 1'b1; mem_we = 1'b0; mem_wdata = 32'h0000_0040; m_rdata = 32'h5555_AAAA;
    next_cycle();
    #1;
    check("rst_wait_gnt", 128'(mem_gnt), 128'h1);
    next_cycle();
    Reset = 1'b1; mem_req = 1'b0;
    next_cycle();
    Reset = 1'b0;
    #1;
    check("rst_wait_clear", obs0(), 128'h0);
    next_cycle();
    if_req = 1'b1;
    #1;
    check("rst_wait_novalid", obs0(), {24'h0, 8'b0000_0001, 96'h0});
    next_cycle();
    #1;
    check("rst_wait_ifgnt", obs0(), {24'h0, 8'b1000_0101, 96'h0});
    next_cycle(); next_cycle();
    m_rdata = 32'h0000_ABCD;
    next_cycle();
    if_req = 1'b0;
    #1;
    check("rst_wait_ifvalid", obs0(), {24'h0, 8'b0100_0000, 32'h0000_ABCD, 64'h0});

    // Starvation: both requests held, SMAX MEM grants then IF then MEM
    do_reset();
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
    gq.delete(); tq.delete();
    for (int c = 0; c < 80 && gq.size() < 6; c++) begin
      if (c > 0) next_cycle();
      m_rdata = $urandom;
      #1;
      if (if_gnt)  begin gq.push_back(1'b0); tq.push_back(c); end
      if (mem_gnt) begin gq.push_back(1'b1); tq.push_back(c); end
    end
    check("starve_grants", 128'(gq.size()), 128'd6);
    for (int g = 0; g < gq.size(); g++) begin
      check($sformatf("starve_owner%0d", g), 128'(gq[g]), (g == SMAX) ? 128'd0 : 128'd1);
      if (g == 0) check("starve_first", 128'(tq[0]), 128'd1);
      else check($sformatf("starve_gap%0d", g), 128'(tq[g] - tq[g-1]), 128'(LAT + 3));
    end

    // Single-cycle latency build: lone MEM read valid in cycle 3
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      mem_req = (c < 3); mem_we = 1'b0;
      m_rdata = (c == 2) ? 32'h5A5A_5A5A : 32'h0;
      #1;
      check($sformatf("lat1_c%0d", c), {94'h0, d1_m_en, d1_mem_valid, d1_mem_rdata},
            {94'h0, (c == 1), (c == 3), ((c >= 3) ? 32'h5A5A_5A5A : 32'h0)});
    end

    // Randomized traffic against the transaction-level model
    do_reset();
    next_free = 0; act = 1'b0; own = 1'b0; ca = 0; starve = 0; a_we = 1'b0;
    a_wd = 32'h0; a_samp = 32'h0; e_ifrd = 32'h0; e_memrd = 32'h0; e_mwd = 32'h0;
    for (int t = 0; t < NRND; t++) begin
      if (t > 0) next_cycle();
      if_hold  = act && !own && (t > ca) && (t < ca + 2 + LAT);
      mem_hold = act &&  own && (t > ca) && (t < ca + 2 + LAT);
      if (!if_hold) begin
        if (!if_req) begin
          if ($urandom_range(2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
        end else if ($urandom_range(3) == 0) if_req = 1'b0;
      end
      if (!mem_hold) begin
        if (!mem_req) begin
          if ($urandom_range(2) == 0) begin
            mem_req = 1'b1; mem_we = 1'($urandom_range(1)); mem_wdata = $urandom;
          end
        end else if ($urandom_range(3) == 0) mem_req = 1'b0;
      end
      m_rdata = $urandom;
      #1;
      e_en = act && (t == ca + 1);
      e_ig = e_en && !own;
      e_mg = e_en && own;
      e_we = e_en && own && a_we;
      e_iv = act && !own && (t == ca + 2 + LAT);
      e_mv = act &&  own && (t == ca + 2 + LAT);
      e_as = act && own && (t >= ca + 1) && (t <= ca + 2 + LAT);
      if (e_en) e_mwd = own ? a_wd : 32'h0;
      if (e_iv) e_ifrd = a_samp;
      if (e_mv) e_memrd = a_we ? 32'h0 : a_samp;
      check($sformatf("rnd_t%0d", t), obs0(),
            {24'h0, e_ig, e_iv, e_mg, e_mv, e_as, e_en, e_we, (if_req & ~e_iv),
             e_ifrd, e_memrd, e_mwd});
      if (act && (t == ca + 1 + LAT)) a_samp = m_rdata;
      if ((t >= next_free) && (if_req || mem_req)) begin
        if_win = if_req && (!mem_req || (starve == SMAX));
        if (if_win) starve = 0;
        else if (if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
        act = 1'b1; ca = t; own = !if_win;
        a_we = !if_win && mem_we; a_wd = mem_wdata;
        next_free = t + 3 + LAT;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
